// File: rtl/ft_lockstep_ctrl.sv
// Dual-core lockstep supervisor: compares fetch streams, checkpoints the last
// agreed fetch address and sequences drain/reset/restore recovery on faults.
module ft_lockstep_ctrl #(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          RESET_CYCLES = 2,
    parameter int          MAX_RETRY    = 3,
    parameter int          CLEAN_WINDOW = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic        instr_req_0_i,
    input  logic        instr_req_1_i,
    input  logic [31:0] instr_addr_0_i,
    input  logic [31:0] instr_addr_1_i,
    input  logic        error_i,
    output logic        fetch_enable_o,
    output logic        core_rst_o,
    output logic [31:0] pc_restore_o,
    output logic        pc_restore_valid_o,
    output logic        recovering_o,
    output logic [7:0]  err_count_o,
    output logic        fatal_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_RESET,
        S_RESTORE,
        S_FATAL
    } state_e;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [7:0] CLEAN_WIN  = 8'(CLEAN_WINDOW);

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [31:0] ckpt_q, ckpt_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  clean_q, clean_d;

    logic        fe_q, fe_d;
    logic        crst_q, crst_d;
    logic        vld_q, vld_d;
    logic        rec_q, rec_d;
    logic        fatal_q, fatal_d;

    logic        both_req;
    logic        mismatch;
    logic        agreed;

    assign both_req = instr_req_0_i & instr_req_1_i;
    assign mismatch = error_i
                    | (instr_req_0_i ^ instr_req_1_i)
                    | (both_req & (instr_addr_0_i != instr_addr_1_i));
    assign agreed   = both_req & (instr_addr_0_i == instr_addr_1_i) & ~error_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            ckpt_q  <= BOOT_ADDR;
            err_q   <= '0;
            retry_q <= '0;
            clean_q <= '0;
            fe_q    <= 1'b0;
            crst_q  <= 1'b0;
            vld_q   <= 1'b0;
            rec_q   <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ckpt_q  <= ckpt_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            clean_q <= clean_d;
            fe_q    <= fe_d;
            crst_q  <= crst_d;
            vld_q   <= vld_d;
            rec_q   <= rec_d;
            fatal_q <= fatal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ckpt_d  = ckpt_q;
        err_d   = err_q;
        retry_d = retry_q;
        clean_d = clean_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_enable_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (mismatch) begin
                    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    clean_d = '0;
                    phase_d = '0;
                    state_d = (retry_d > RETRY_MAX) ? S_FATAL : S_HALT;
                end else begin
                    if (agreed) begin
                        ckpt_d  = instr_addr_0_i;
                        // Saturate so a long clean stretch keeps retries cleared
                        clean_d = (clean_q >= CLEAN_WIN) ? clean_q : clean_q + 8'd1;
                        if (clean_d >= CLEAN_WIN) begin
                            retry_d = '0;
                        end
                    end
                    if (!fetch_enable_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (phase_q == DRAIN_LAST) begin
                    phase_d = '0;
                    state_d = S_RESET;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_RESET: begin
                if (phase_q == RESET_LAST) begin
                    phase_d = '0;
                    state_d = S_RESTORE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_RESTORE: begin
                state_d = fetch_enable_i ? S_RUN : S_IDLE;
            end
            S_FATAL: begin
                state_d = S_FATAL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so every port comes straight off a flop
    always_comb begin
        fe_d    = 1'b0;
        crst_d  = 1'b0;
        vld_d   = 1'b0;
        rec_d   = 1'b0;
        fatal_d = 1'b0;
        case (state_d)
            S_RUN: begin
                fe_d = 1'b1;
            end
            S_HALT: begin
                rec_d = 1'b1;
            end
            S_RESET: begin
                rec_d  = 1'b1;
                crst_d = 1'b1;
            end
            S_RESTORE: begin
                rec_d = 1'b1;
                vld_d = 1'b1;
            end
            S_FATAL: begin
                crst_d  = 1'b1;
                fatal_d = 1'b1;
            end
            default: begin
                fe_d = 1'b0;
            end
        endcase
    end

    assign fetch_enable_o     = fe_q;
    assign core_rst_o         = crst_q;
    assign pc_restore_o       = ckpt_q;
    assign pc_restore_valid_o = vld_q;
    assign recovering_o       = rec_q;
    assign err_count_o        = err_q;
    assign fatal_o            = fatal_q;

endmodule
